// File: rtl/apb_uart_fifo_regs.sv
// apb_uart_fifo_regs: APB register and FIFO front-end for the UART serial engine.
// Buffers TX/RX characters and provides thresholds, sticky error flags, an RX idle timeout and a level IRQ.
module apb_uart_fifo_regs #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int TO_W     = 8
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic [5:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [15:0]       PWDATA,
  output logic [15:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  input  logic [DATA_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  input  logic              RX_PERR,
  input  logic              RX_FERR,
  input  logic              BAUD_TICK,
  output logic              IRQ
);

  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam logic [TXAW:0] TX_FULL_CNT = (TXAW+1)'(TX_DEPTH);
  localparam logic [RXAW:0] RX_FULL_CNT = (RXAW+1)'(RX_DEPTH);

  localparam logic [3:0] ADDR_TXDATA  = 4'h0;
  localparam logic [3:0] ADDR_RXDATA  = 4'h1;
  localparam logic [3:0] ADDR_CTRL    = 4'h2;
  localparam logic [3:0] ADDR_THRESH  = 4'h3;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_INTEN   = 4'h5;
  localparam logic [3:0] ADDR_INTSTAT = 4'h6;
  localparam logic [3:0] ADDR_COUNT   = 4'h7;
  localparam logic [3:0] ADDR_TIMEOUT = 4'h8;

  logic [3:0]  w_idx;
  logic        w_wrEn;
  logic        w_rdSetup;
  logic        w_rdAccess;
  logic        w_unused;

  logic [DATA_W-1:0] r_txMem [TX_DEPTH];
  logic [TXAW:0]     r_txWr;
  logic [TXAW:0]     r_txRd;
  logic [TXAW:0]     w_txCnt;
  logic              w_txEmpty;
  logic              w_txFull;
  logic              w_txPush;
  logic              w_txPop;
  logic              w_txFlush;
  logic              w_txAccept;
  logic              w_txOvf;

  logic [DATA_W-1:0] r_rxMem [RX_DEPTH];
  logic [RXAW:0]     r_rxWr;
  logic [RXAW:0]     r_rxRd;
  logic [RXAW:0]     w_rxCnt;
  logic              w_rxEmpty;
  logic              w_rxFull;
  logic              w_rxPop;
  logic              w_rxFlush;
  logic              w_rxAccept;
  logic              w_rxOvf;
  logic [DATA_W-1:0] w_rxHead;

  logic [7:0]        r_txThr;
  logic [7:0]        r_rxThr;
  logic [6:0]        r_intEn;
  logic [4:0]        r_sticky;
  logic [TO_W-1:0]   r_timeout;
  logic [TO_W-1:0]   r_toCnt;
  logic [TO_W-1:0]   w_toNext;
  logic              w_toClr;
  logic              w_toAtLimit;
  logic              w_toHit;
  logic              w_txLow;
  logic              w_rxHigh;
  logic [6:0]        w_intStat;
  logic [4:0]        w_setBits;
  logic [15:0]       w_rdData;
  logic [15:0]       r_prdata;
  logic              r_irq;

  assign w_idx      = PADDR[5:2];
  assign w_wrEn     = PSEL & PENABLE & PWRITE;
  assign w_rdSetup  = PSEL & ~PENABLE & ~PWRITE;
  assign w_rdAccess = PSEL & PENABLE & ~PWRITE;
  assign w_unused   = ^PADDR[1:0];

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & (w_idx > ADDR_TIMEOUT);
  assign PRDATA  = r_prdata;
  assign IRQ     = r_irq;

  // Pointers carry one extra wrap bit so that wr-rd gives the occupancy directly.
  assign w_txCnt    = r_txWr - r_txRd;
  assign w_txEmpty  = (w_txCnt == '0);
  assign w_txFull   = (w_txCnt == TX_FULL_CNT);
  assign TX_VALID   = ~w_txEmpty;
  assign TX_DATA    = r_txMem[r_txRd[TXAW-1:0]];
  assign w_txPop    = TX_VALID & TX_READY;
  assign w_txPush   = w_wrEn & (w_idx == ADDR_TXDATA);
  assign w_txFlush  = w_wrEn & (w_idx == ADDR_CTRL) & PWDATA[0];
  assign w_txAccept = w_txPush & (~w_txFull | w_txPop) & ~w_txFlush;
  assign w_txOvf    = w_txPush & w_txFull & ~w_txPop & ~w_txFlush;

  assign w_rxCnt    = r_rxWr - r_rxRd;
  assign w_rxEmpty  = (w_rxCnt == '0);
  assign w_rxFull   = (w_rxCnt == RX_FULL_CNT);
  assign w_rxHead   = r_rxMem[r_rxRd[RXAW-1:0]];
  assign w_rxPop    = w_rdAccess & (w_idx == ADDR_RXDATA) & ~w_rxEmpty;
  assign w_rxFlush  = w_wrEn & (w_idx == ADDR_CTRL) & PWDATA[1];
  assign w_rxAccept = RX_VALID & (~w_rxFull | w_rxPop) & ~w_rxFlush;
  assign w_rxOvf    = RX_VALID & w_rxFull & ~w_rxPop & ~w_rxFlush;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_txWr <= '0;
      r_txRd <= '0;
      for (int i = 0; i < TX_DEPTH; i++) r_txMem[i] <= '0;
    end else if (w_txFlush) begin
      r_txWr <= '0;
      r_txRd <= '0;
    end else begin
      if (w_txAccept) begin
        r_txMem[r_txWr[TXAW-1:0]] <= PWDATA[DATA_W-1:0];
        r_txWr <= r_txWr + 1'b1;
      end
      if (w_txPop) r_txRd <= r_txRd + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_rxWr <= '0;
      r_rxRd <= '0;
      for (int i = 0; i < RX_DEPTH; i++) r_rxMem[i] <= '0;
    end else if (w_rxFlush) begin
      r_rxWr <= '0;
      r_rxRd <= '0;
    end else begin
      if (w_rxAccept) begin
        r_rxMem[r_rxWr[RXAW-1:0]] <= RX_DATA;
        r_rxWr <= r_rxWr + 1'b1;
      end
      if (w_rxPop) r_rxRd <= r_rxRd + 1'b1;
    end
  end

  // Idle timer runs only while RX holds unread data; it parks at the limit so RXTO fires once.
  assign w_toNext    = r_toCnt + 1'b1;
  assign w_toClr     = RX_VALID | w_rxPop | w_rxFlush | w_rxEmpty;
  assign w_toAtLimit = (r_timeout != '0) & (r_toCnt == r_timeout);
  assign w_toHit     = ~w_toClr & BAUD_TICK & ~w_toAtLimit & (r_timeout != '0) & (w_toNext == r_timeout);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) r_toCnt <= '0;
    else if (w_toClr) r_toCnt <= '0;
    else if (BAUD_TICK && !w_toAtLimit) r_toCnt <= w_toNext;
  end

  assign w_txLow   = (8'(w_txCnt) <= r_txThr);
  assign w_rxHigh  = (8'(w_rxCnt) >= r_rxThr);
  assign w_intStat = {w_rxHigh, w_txLow, r_sticky};
  assign w_setBits = {w_toHit, RX_VALID & RX_FERR, RX_VALID & RX_PERR, w_rxOvf, w_txOvf};

  // Hardware set is ORed after the W1C mask, so a coincident set survives the clear.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_txThr   <= '0;
      r_rxThr   <= '0;
      r_intEn   <= '0;
      r_sticky  <= '0;
      r_timeout <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wrEn && w_idx == ADDR_THRESH) begin
        r_txThr <= PWDATA[7:0];
        r_rxThr <= PWDATA[15:8];
      end
      if (w_wrEn && w_idx == ADDR_INTEN) r_intEn <= PWDATA[6:0];
      if (w_wrEn && w_idx == ADDR_TIMEOUT) r_timeout <= PWDATA[TO_W-1:0];
      if (w_wrEn && w_idx == ADDR_INTSTAT) r_sticky <= (r_sticky & ~PWDATA[4:0]) | w_setBits;
      else r_sticky <= r_sticky | w_setBits;
      r_irq <= |(w_intStat & r_intEn);
    end
  end

  always_comb begin
    w_rdData = '0;
    case (w_idx)
      ADDR_RXDATA:  if (!w_rxEmpty) w_rdData = 16'(w_rxHead);
      ADDR_THRESH:  w_rdData = {r_rxThr, r_txThr};
      ADDR_STATUS:  w_rdData = {10'd0, w_rxHigh, w_txLow, w_rxFull, w_rxEmpty, w_txFull, w_txEmpty};
      ADDR_INTEN:   w_rdData = {9'd0, r_intEn};
      ADDR_INTSTAT: w_rdData = {9'd0, w_intStat};
      ADDR_COUNT:   w_rdData = {8'(w_rxCnt), 8'(w_txCnt)};
      ADDR_TIMEOUT: w_rdData = 16'(r_timeout);
      default:      w_rdData = '0;
    endcase
  end

  // Read data is captured in the setup phase so it is stable for the whole access phase.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) r_prdata <= '0;
    else if (w_rdSetup) r_prdata <= w_rdData;
  end

endmodule

// File: tb/tb_apb_uart_fifo_regs.sv
// tb_apb_uart_fifo_regs: directed stimulus for apb_uart_fifo_regs, checked every cycle against a
// queue-based behavioural model plus hand-computed register values.
`timescale 1ns/1ps
module tb_apb_uart_fifo_regs;

  localparam int DATA_W = 8;
  localparam int TXD    = 16;
  localparam int RXD    = 16;
  localparam int TO_W   = 8;

  logic              PCLK = 1'b0;
  logic              PRESETN = 1'b0;
  logic [5:0]        PADDR = '0;
  logic              PSEL = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE = 1'b0;
  logic [15:0]       PWDATA = '0;
  logic [15:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_READY = 1'b0;
  logic [DATA_W-1:0] RX_DATA = '0;
  logic              RX_VALID = 1'b0;
  logic              RX_PERR = 1'b0;
  logic              RX_FERR = 1'b0;
  logic              BAUD_TICK = 1'b0;
  logic              IRQ;

  int checks = 0;
  int errors = 0;

  apb_uart_fifo_regs #(.DATA_W(DATA_W), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .TO_W(TO_W)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .RX_PERR(RX_PERR), .RX_FERR(RX_FERR), .BAUD_TICK(BAUD_TICK), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  logic [DATA_W-1:0] txq[$];
  logic [DATA_W-1:0] rxq[$];
  logic [4:0]        mSticky = '0;
  logic [6:0]        mIntEn = '0;
  logic [7:0]        mTxThr = '0;
  logic [7:0]        mRxThr = '0;
  logic [TO_W-1:0]   mTimeout = '0;
  int                mToCnt = 0;
  logic              expIrq = 1'b0;
  logic [15:0]       expPrdata = '0;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [6:0] modelIntStat();
    logic txLow  = (txq.size() <= int'(mTxThr));
    logic rxHigh = (rxq.size() >= int'(mRxThr));
    return {rxHigh, txLow, mSticky};
  endfunction

  function automatic logic [15:0] modelRead(input logic [3:0] idx);
    logic [15:0] v = '0;
    case (idx)
      4'h1: if (rxq.size() != 0) v = 16'(rxq[0]);
      4'h3: v = {mRxThr, mTxThr};
      4'h4: begin
        v[0] = (txq.size() == 0);
        v[1] = (txq.size() == TXD);
        v[2] = (rxq.size() == 0);
        v[3] = (rxq.size() == RXD);
        v[5:4] = modelIntStat() >> 5;
      end
      4'h5: v = 16'(mIntEn);
      4'h6: v = 16'(modelIntStat());
      4'h7: v = {8'(rxq.size()), 8'(txq.size())};
      4'h8: v = 16'(mTimeout);
      default: v = '0;
    endcase
    return v;
  endfunction

  // One clock of the specified behaviour, evaluated on the pre-edge state and inputs.
  task automatic modelStep();
    logic [3:0] idx = PADDR[5:2];
    bit wr = PSEL && PENABLE && PWRITE;
    bit rdSetup = PSEL && !PENABLE && !PWRITE;
    bit rdAcc = PSEL && PENABLE && !PWRITE;
    bit rxWasEmpty = (rxq.size() == 0);
    bit txPop = (txq.size() != 0) && TX_READY;
    bit txFlush = wr && idx == 4'h2 && PWDATA[0];
    bit rxFlush = wr && idx == 4'h2 && PWDATA[1];
    bit rxPop = rdAcc && idx == 4'h1 && !rxWasEmpty;
    logic [4:0] setBits = '0;
    expIrq = |(modelIntStat() & mIntEn);
    if (rdSetup) expPrdata = modelRead(idx);
    if (txFlush) txq.delete();
    else begin
      if (txPop) void'(txq.pop_front());
      if (wr && idx == 4'h0) begin
        if (txq.size() < TXD) txq.push_back(PWDATA[DATA_W-1:0]);
        else setBits[0] = 1'b1;
      end
    end
    if (rxFlush) rxq.delete();
    else begin
      if (rxPop) void'(rxq.pop_front());
      if (RX_VALID) begin
        if (rxq.size() < RXD) rxq.push_back(RX_DATA);
        else setBits[1] = 1'b1;
      end
    end
    if (RX_VALID && RX_PERR) setBits[2] = 1'b1;
    if (RX_VALID && RX_FERR) setBits[3] = 1'b1;
    if (RX_VALID || rxPop || rxFlush || rxWasEmpty) mToCnt = 0;
    else if (BAUD_TICK && !(mTimeout != 0 && mToCnt == int'(mTimeout))) begin
      mToCnt = (mToCnt + 1) % (1 << TO_W);
      if (mTimeout != 0 && mToCnt == int'(mTimeout)) setBits[4] = 1'b1;
    end
    if (wr && idx == 4'h6) mSticky = (mSticky & ~PWDATA[4:0]) | setBits;
    else mSticky = mSticky | setBits;
    if (wr && idx == 4'h3) {mRxThr, mTxThr} = PWDATA;
    if (wr && idx == 4'h5) mIntEn = PWDATA[6:0];
    if (wr && idx == 4'h8) mTimeout = PWDATA[TO_W-1:0];
  endtask

  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      txq.delete();
      rxq.delete();
      mSticky = '0;
      mIntEn = '0;
      mTxThr = '0;
      mRxThr = '0;
      mTimeout = '0;
      mToCnt = 0;
      expIrq = 1'b0;
      expPrdata = '0;
    end else begin
      modelStep();
    end
  end

  // Outputs are compared against the model mid-cycle on every clock out of reset.
  always @(negedge PCLK) begin
    if (PRESETN) begin
      checkOutput("TX_VALID", 16'(TX_VALID), 16'(txq.size() != 0));
      if (txq.size() != 0) checkOutput("TX_DATA", 16'(TX_DATA), 16'(txq[0]));
      checkOutput("IRQ", 16'(IRQ), 16'(expIrq));
      checkOutput("PREADY", 16'(PREADY), 16'd1);
      if (PSEL && PENABLE) checkOutput("PSLVERR", 16'(PSLVERR), 16'(PADDR[5:2] > 4'h8));
      if (PSEL && PENABLE && !PWRITE) checkOutput("PRDATA", PRDATA, expPrdata);
    end
  end

  task automatic applyStimulus(input logic rxV, input logic [DATA_W-1:0] rxD, input logic perr,
                               input logic ferr, input logic txR, input logic tick);
    @(posedge PCLK);
    #1;
    RX_VALID = rxV;
    RX_DATA = rxD;
    RX_PERR = perr;
    RX_FERR = ferr;
    TX_READY = txR;
    BAUD_TICK = tick;
  endtask

  task automatic apbWrite(input logic [5:0] addr, input logic [15:0] data);
    @(posedge PCLK);
    #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK);
    #1;
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbRead(input logic [5:0] addr, output logic [15:0] data, output logic err,
                         input logic pushEn, input logic [DATA_W-1:0] pushData);
    @(posedge PCLK);
    #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK);
    #1;
    PENABLE = 1'b1;
    if (pushEn) begin
      RX_VALID = 1'b1;
      RX_DATA = pushData;
    end
    @(negedge PCLK);
    data = PRDATA;
    err = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    RX_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    logic er;

    repeat (3) @(posedge PCLK);
    #1;
    PRESETN = 1'b1;
    checkOutput("reset PRDATA", PRDATA, 16'h0000);
    checkOutput("reset IRQ", 16'(IRQ), 16'h0000);
    checkOutput("reset TX_VALID", 16'(TX_VALID), 16'h0000);
    checkOutput("reset TX_DATA", 16'(TX_DATA), 16'h0000);
    apbRead(6'h10, rd, er, 1'b0, '0);
    checkOutput("reset STATUS", rd, 16'h0035);
    apbRead(6'h1C, rd, er, 1'b0, '0);
    checkOutput("reset COUNT", rd, 16'h0000);

    $display("[TB] TX push and drain");
    apbWrite(6'h00, 16'h0041);
    apbWrite(6'h00, 16'h0042);
    apbRead(6'h1C, rd, er, 1'b0, '0);
    checkOutput("tx COUNT", rd, 16'h0002);
    checkOutput("tx head", 16'(TX_DATA), 16'h0041);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("tx second", 16'(TX_DATA), 16'h0042);
    checkOutput("tx valid mid", 16'(TX_VALID), 16'h0001);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("tx drained", 16'(TX_VALID), 16'h0000);

    $display("[TB] RX overflow and drain");
    for (int i = 1; i <= 17; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    apbRead(6'h10, rd, er, 1'b0, '0);
    checkOutput("rx full STATUS", rd, 16'h0039);
    apbRead(6'h1C, rd, er, 1'b0, '0);
    checkOutput("rx full COUNT", rd, 16'h1000);
    apbRead(6'h18, rd, er, 1'b0, '0);
    checkOutput("rx ovf INTSTAT", rd, 16'h0062);
    for (int i = 1; i <= 17; i++) begin
      apbRead(6'h04, rd, er, 1'b0, '0);
      checkOutput("rx drain", rd, (i <= 16) ? 16'(i) : 16'h0000);
    end

    $display("[TB] RX push while full with same-cycle pop");
    apbWrite(6'h18, 16'h001F);
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, DATA_W'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    apbRead(6'h04, rd, er, 1'b1, 8'h77);
    checkOutput("rx pop head", rd, 16'h0011);
    apbRead(6'h18, rd, er, 1'b0, '0);
    checkOutput("rx no ovf", rd, 16'h0060);
    apbRead(6'h1C, rd, er, 1'b0, '0);
    checkOutput("rx count held", rd, 16'h1000);

    $display("[TB] overflow interrupt");
    apbWrite(6'h14, 16'h0002);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("irq before", 16'(IRQ), 16'h0000);
    @(posedge PCLK);
    #1;
    checkOutput("irq set", 16'(IRQ), 16'h0001);
    apbWrite(6'h18, 16'h0002);
    checkOutput("irq hold", 16'(IRQ), 16'h0001);
    @(posedge PCLK);
    #1;
    checkOutput("irq clear", 16'(IRQ), 16'h0000);
    apbWrite(6'h14, 16'h0000);

    $display("[TB] RX idle timeout");
    apbWrite(6'h08, 16'h0002);
    apbWrite(6'h20, 16'h0004);
    apbWrite(6'h18, 16'h001F);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    apbRead(6'h18, rd, er, 1'b0, '0);
    checkOutput("rxto set", rd, 16'h0070);
    apbWrite(6'h20, 16'h0000);
    apbWrite(6'h18, 16'h0010);
    repeat (10) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    apbRead(6'h18, rd, er, 1'b0, '0);
    checkOutput("rxto disabled", rd, 16'h0060);
    apbRead(6'h24, rd, er, 1'b0, '0);
    checkOutput("unmapped PSLVERR", 16'(er), 16'h0001);
    checkOutput("unmapped PRDATA", rd, 16'h0000);

    $display("[TB] error flags, TX overflow, thresholds, flush");
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    apbRead(6'h18, rd, er, 1'b0, '0);
    checkOutput("perr ferr", rd, 16'h006C);
    for (int i = 1; i <= 17; i++) apbWrite(6'h00, 16'(8'hA0 + i));
    apbRead(6'h1C, rd, er, 1'b0, '0);
    checkOutput("tx full COUNT", rd, 16'h0210);
    apbRead(6'h18, rd, er, 1'b0, '0);
    checkOutput("tx ovf INTSTAT", rd, 16'h004D);
    apbWrite(6'h0C, 16'h0410);
    apbRead(6'h10, rd, er, 1'b0, '0);
    checkOutput("thresh STATUS", rd, 16'h0012);
    apbWrite(6'h08, 16'h0001);
    apbRead(6'h1C, rd, er, 1'b0, '0);
    checkOutput("tx flushed COUNT", rd, 16'h0200);

    $display("[TB] reset mid-transfer");
    apbWrite(6'h00, 16'h0055);
    apbWrite(6'h00, 16'h0066);
    @(posedge PCLK);
    #1;
    PRESETN = 1'b0;
    #1;
    checkOutput("mid reset TX_VALID", 16'(TX_VALID), 16'h0000);
    checkOutput("mid reset TX_DATA", 16'(TX_DATA), 16'h0000);
    checkOutput("mid reset PRDATA", PRDATA, 16'h0000);
    repeat (2) @(posedge PCLK);
    #1;
    PRESETN = 1'b1;
    apbRead(6'h10, rd, er, 1'b0, '0);
    checkOutput("post reset STATUS", rd, 16'h0035);
    apbRead(6'h1C, rd, er, 1'b0, '0);
    checkOutput("post reset COUNT", rd, 16'h0000);

    repeat (3) @(posedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
